// File: rtl/reservation_station.sv
// Dual-dispatch, single-issue reservation station with two-CDB operand capture,
// lowest-index issue selection and speculative flush/resolve.
module reservation_station #(
    parameter int ENTRIES = 8,
    parameter int IDXW    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            disp1_valid,
    input  logic            disp2_valid,
    input  logic [3:0]      rstag1,
    input  logic [3:0]      rstag2,
    input  logic [3:0]      rstag3,
    input  logic [3:0]      rstag4,
    input  logic [15:0]     dataRs1,
    input  logic [15:0]     dataRt1,
    input  logic [15:0]     dataRs2,
    input  logic [15:0]     dataRt2,
    input  logic [15:0]     imm1,
    input  logic [15:0]     imm2,
    input  logic [5:0]      ctrl1,
    input  logic [5:0]      ctrl2,
    input  logic [2:0]      func1,
    input  logic [2:0]      func2,
    input  logic [3:0]      robDest1,
    input  logic [3:0]      robDest2,
    input  logic            spec1,
    input  logic            spec2,
    input  logic            cdb1_valid,
    input  logic            cdb2_valid,
    input  logic [3:0]      cdb1_tag,
    input  logic [3:0]      cdb2_tag,
    input  logic [15:0]     cdb1_data,
    input  logic [15:0]     cdb2_data,
    input  logic            flush,
    input  logic            spec_resolve,
    input  logic            issue_ready,
    output logic            issue_valid,
    output logic [15:0]     issue_opA,
    output logic [15:0]     issue_opB,
    output logic [15:0]     issue_imm,
    output logic [5:0]      issue_ctrl,
    output logic [2:0]      issue_func,
    output logic [3:0]      issue_robDest,
    output logic [IDXW:0]   free_count,
    output logic            rs_stall
);

    logic [ENTRIES-1:0] valid_r;
    logic [ENTRIES-1:0] spec_r;
    logic [ENTRIES-1:0] rdy_a_r;
    logic [ENTRIES-1:0] rdy_b_r;
    logic [3:0]         tag_a_r   [ENTRIES];
    logic [3:0]         tag_b_r   [ENTRIES];
    logic [15:0]        data_a_r  [ENTRIES];
    logic [15:0]        data_b_r  [ENTRIES];
    logic [15:0]        imm_r     [ENTRIES];
    logic [5:0]         ctrl_r    [ENTRIES];
    logic [2:0]         func_r    [ENTRIES];
    logic [3:0]         rob_r     [ENTRIES];
    logic [IDXW:0]      free_count_r;
    logic               rs_stall_r;

    logic               cand_found_s;
    logic [IDXW-1:0]    cand_idx_s;
    logic               free1_found_s;
    logic [IDXW-1:0]    free1_idx_s;
    logic               free2_found_s;
    logic [IDXW-1:0]    free2_idx_s;
    logic               accept_s;
    logic               we1_s;
    logic               we2_s;
    logic [IDXW-1:0]    idx2_s;
    logic               issue_fire_s;
    logic [ENTRIES-1:0] valid_nxt_s;
    logic [IDXW:0]      valid_cnt_s;
    logic [IDXW:0]      free_cnt_nxt_s;
    logic [16:0]        d1a_s, d1b_s, d2a_s, d2b_s;
    logic [16:0]        cap_a_s   [ENTRIES];
    logic [16:0]        cap_b_s   [ENTRIES];

    // Returns {ready, data}: tag 0 means the data is already valid; otherwise
    // look for a same-cycle CDB match, cdb1 winning over cdb2.
    function automatic logic [16:0] resolve_op(
        input logic [3:0]  tag,
        input logic [15:0] data,
        input logic        c1_v,
        input logic [3:0]  c1_t,
        input logic [15:0] c1_d,
        input logic        c2_v,
        input logic [3:0]  c2_t,
        input logic [15:0] c2_d
    );
        logic [16:0] res;
        if (tag == 4'd0) begin
            res = {1'b1, data};
        end else if (c1_v && (c1_t == tag)) begin
            res = {1'b1, c1_d};
        end else if (c2_v && (c2_t == tag)) begin
            res = {1'b1, c2_d};
        end else begin
            res = {1'b0, data};
        end
        return res;
    endfunction

    // Operand resolution for incoming dispatch slots and resident entries
    always_comb begin
        d1a_s = resolve_op(rstag1, dataRs1, cdb1_valid, cdb1_tag, cdb1_data, cdb2_valid, cdb2_tag, cdb2_data);
        d1b_s = resolve_op(rstag2, dataRt1, cdb1_valid, cdb1_tag, cdb1_data, cdb2_valid, cdb2_tag, cdb2_data);
        d2a_s = resolve_op(rstag3, dataRs2, cdb1_valid, cdb1_tag, cdb1_data, cdb2_valid, cdb2_tag, cdb2_data);
        d2b_s = resolve_op(rstag4, dataRt2, cdb1_valid, cdb1_tag, cdb1_data, cdb2_valid, cdb2_tag, cdb2_data);
        for (int i = 0; i < ENTRIES; i++) begin
            cap_a_s[i] = resolve_op(tag_a_r[i], data_a_r[i], cdb1_valid, cdb1_tag, cdb1_data,
                                    cdb2_valid, cdb2_tag, cdb2_data);
            cap_b_s[i] = resolve_op(tag_b_r[i], data_b_r[i], cdb1_valid, cdb1_tag, cdb1_data,
                                    cdb2_valid, cdb2_tag, cdb2_data);
        end
    end

    // Lowest-index ready entry and the two lowest free entries (registered view)
    always_comb begin
        cand_found_s  = 1'b0;
        cand_idx_s    = '0;
        free1_found_s = 1'b0;
        free1_idx_s   = '0;
        free2_found_s = 1'b0;
        free2_idx_s   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_r[i] && rdy_a_r[i] && rdy_b_r[i]) begin
                cand_found_s = 1'b1;
                cand_idx_s   = IDXW'(i);
            end else begin
                cand_found_s = cand_found_s;
            end
            if (!valid_r[i]) begin
                free2_found_s = free1_found_s;
                free2_idx_s   = free1_idx_s;
                free1_found_s = 1'b1;
                free1_idx_s   = IDXW'(i);
            end else begin
                free1_found_s = free1_found_s;
            end
        end
    end

    // Dispatch acceptance and slot-to-entry allocation
    always_comb begin
        accept_s = !rs_stall_r && !flush;
        we1_s    = disp1_valid && accept_s && free1_found_s;
        if (we1_s) begin
            we2_s  = disp2_valid && accept_s && free2_found_s;
            idx2_s = free2_idx_s;
        end else begin
            we2_s  = disp2_valid && accept_s && free1_found_s;
            idx2_s = free1_idx_s;
        end
    end

    // Issue payload is combinational from the selected entry; flush masks valid
    always_comb begin
        issue_valid   = cand_found_s && !flush;
        issue_opA     = 16'd0;
        issue_opB     = 16'd0;
        issue_imm     = 16'd0;
        issue_ctrl    = 6'd0;
        issue_func    = 3'd0;
        issue_robDest = 4'd0;
        if (cand_found_s) begin
            issue_opA     = data_a_r[cand_idx_s];
            issue_opB     = data_b_r[cand_idx_s];
            issue_imm     = imm_r[cand_idx_s];
            issue_ctrl    = ctrl_r[cand_idx_s];
            issue_func    = func_r[cand_idx_s];
            issue_robDest = rob_r[cand_idx_s];
        end else begin
            issue_robDest = 4'd0;
        end
        issue_fire_s = issue_valid && issue_ready;
    end

    // Next-cycle occupancy; free count derived from it so it can never wrap
    always_comb begin
        valid_nxt_s = valid_r;
        valid_cnt_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_fire_s && (cand_idx_s == IDXW'(i))) begin
                valid_nxt_s[i] = 1'b0;
            end else if (flush && spec_r[i]) begin
                valid_nxt_s[i] = 1'b0;
            end else begin
                valid_nxt_s[i] = valid_r[i];
            end
            if ((we1_s && (free1_idx_s == IDXW'(i))) || (we2_s && (idx2_s == IDXW'(i)))) begin
                valid_nxt_s[i] = 1'b1;
            end else begin
                valid_nxt_s[i] = valid_nxt_s[i];
            end
            valid_cnt_s = valid_cnt_s + {{IDXW{1'b0}}, valid_nxt_s[i]};
        end
        free_cnt_nxt_s = (IDXW + 1)'(ENTRIES) - valid_cnt_s;
    end

    // Entry state, free count and stall registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= '0;
            spec_r       <= '0;
            rdy_a_r      <= '0;
            rdy_b_r      <= '0;
            free_count_r <= (IDXW + 1)'(ENTRIES);
            rs_stall_r   <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_a_r[i]  <= 4'd0;
                tag_b_r[i]  <= 4'd0;
                data_a_r[i] <= 16'd0;
                data_b_r[i] <= 16'd0;
                imm_r[i]    <= 16'd0;
                ctrl_r[i]   <= 6'd0;
                func_r[i]   <= 3'd0;
                rob_r[i]    <= 4'd0;
            end
        end else begin
            valid_r      <= valid_nxt_s;
            free_count_r <= free_cnt_nxt_s;
            rs_stall_r   <= (free_cnt_nxt_s < (IDXW + 1)'(2));
            for (int i = 0; i < ENTRIES; i++) begin
                if (we1_s && (free1_idx_s == IDXW'(i))) begin
                    spec_r[i]                  <= spec1;
                    {rdy_a_r[i], data_a_r[i]}  <= d1a_s;
                    {rdy_b_r[i], data_b_r[i]}  <= d1b_s;
                    tag_a_r[i]                 <= rstag1;
                    tag_b_r[i]                 <= rstag2;
                    imm_r[i]                   <= imm1;
                    ctrl_r[i]                  <= ctrl1;
                    func_r[i]                  <= func1;
                    rob_r[i]                   <= robDest1;
                end else if (we2_s && (idx2_s == IDXW'(i))) begin
                    spec_r[i]                  <= spec2;
                    {rdy_a_r[i], data_a_r[i]}  <= d2a_s;
                    {rdy_b_r[i], data_b_r[i]}  <= d2b_s;
                    tag_a_r[i]                 <= rstag3;
                    tag_b_r[i]                 <= rstag4;
                    imm_r[i]                   <= imm2;
                    ctrl_r[i]                  <= ctrl2;
                    func_r[i]                  <= func2;
                    rob_r[i]                   <= robDest2;
                end else begin
                    if (valid_r[i] && !rdy_a_r[i]) begin
                        {rdy_a_r[i], data_a_r[i]} <= cap_a_s[i];
                    end
                    if (valid_r[i] && !rdy_b_r[i]) begin
                        {rdy_b_r[i], data_b_r[i]} <= cap_b_s[i];
                    end
                    if (spec_resolve && !flush) begin
                        spec_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign free_count = free_count_r;
    assign rs_stall   = rs_stall_r;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected issue payloads are queued at
// dispatch and matched by ROB tag whenever the station issues.
module tb_reservation_station;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [5:0]  ctrl;
        logic [2:0]  func;
        logic [3:0]  rob;
        logic        spec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp1_valid, disp2_valid;
    logic [3:0]  rstag1, rstag2, rstag3, rstag4;
    logic [15:0] dataRs1, dataRt1, dataRs2, dataRt2, imm1, imm2;
    logic [5:0]  ctrl1, ctrl2;
    logic [2:0]  func1, func2;
    logic [3:0]  robDest1, robDest2;
    logic        spec1, spec2;
    logic        cdb1_valid, cdb2_valid;
    logic [3:0]  cdb1_tag, cdb2_tag;
    logic [15:0] cdb1_data, cdb2_data;
    logic        flush, spec_resolve, issue_ready;
    logic        issue_valid;
    logic [15:0] issue_opA, issue_opB, issue_imm;
    logic [5:0]  issue_ctrl;
    logic [2:0]  issue_func;
    logic [3:0]  issue_robDest;
    logic [3:0]  free_count;
    logic        rs_stall;

    exp_t sb_q[$];
    int   chk_cnt   = 0;
    int   pass_cnt  = 0;
    int   issue_cnt = 0;
    int   snap_cnt;

    reservation_station #(.ENTRIES(8), .IDXW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp1_valid(disp1_valid), .disp2_valid(disp2_valid),
        .rstag1(rstag1), .rstag2(rstag2), .rstag3(rstag3), .rstag4(rstag4),
        .dataRs1(dataRs1), .dataRt1(dataRt1), .dataRs2(dataRs2), .dataRt2(dataRt2),
        .imm1(imm1), .imm2(imm2), .ctrl1(ctrl1), .ctrl2(ctrl2),
        .func1(func1), .func2(func2), .robDest1(robDest1), .robDest2(robDest2),
        .spec1(spec1), .spec2(spec2),
        .cdb1_valid(cdb1_valid), .cdb2_valid(cdb2_valid),
        .cdb1_tag(cdb1_tag), .cdb2_tag(cdb2_tag),
        .cdb1_data(cdb1_data), .cdb2_data(cdb2_data),
        .flush(flush), .spec_resolve(spec_resolve), .issue_ready(issue_ready),
        .issue_valid(issue_valid), .issue_opA(issue_opA), .issue_opB(issue_opB),
        .issue_imm(issue_imm), .issue_ctrl(issue_ctrl), .issue_func(issue_func),
        .issue_robDest(issue_robDest), .free_count(free_count), .rs_stall(rs_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_pulses();
        disp1_valid = 1'b0; disp2_valid = 1'b0;
        cdb1_valid = 1'b0; cdb2_valid = 1'b0;
        flush = 1'b0; spec_resolve = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        clear_pulses();
    endtask

    // Drive one dispatch slot; expected operands are supplied by the caller
    task automatic drive_slot(input int s, input logic [3:0] ta, input logic [3:0] tb,
                              input logic [15:0] da, input logic [15:0] db,
                              input logic [3:0] rob, input logic sp,
                              input logic [15:0] ea, input logic [15:0] eb, input bit push);
        exp_t e;
        e.a = ea; e.b = eb; e.imm = {12'h1A0, rob}; e.ctrl = {2'b10, rob};
        e.func = rob[2:0]; e.rob = rob; e.spec = sp;
        if (s == 1) begin
            disp1_valid = 1'b1; rstag1 = ta; rstag2 = tb; dataRs1 = da; dataRt1 = db;
            imm1 = e.imm; ctrl1 = e.ctrl; func1 = e.func; robDest1 = rob; spec1 = sp;
        end else begin
            disp2_valid = 1'b1; rstag3 = ta; rstag4 = tb; dataRs2 = da; dataRt2 = db;
            imm2 = e.imm; ctrl2 = e.ctrl; func2 = e.func; robDest2 = rob; spec2 = sp;
        end
        if (push) sb_q.push_back(e);
    endtask

    task automatic cdb(input int n, input logic [3:0] tag, input logic [15:0] data);
        if (n == 1) begin
            cdb1_valid = 1'b1; cdb1_tag = tag; cdb1_data = data;
        end else begin
            cdb2_valid = 1'b1; cdb2_tag = tag; cdb2_data = data;
        end
    endtask

    task automatic model_flush();
        for (int j = sb_q.size() - 1; j >= 0; j--) if (sb_q[j].spec) sb_q.delete(j);
    endtask

    // Scoreboard: every accepted issue must match a pending expectation
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            int k;
            k = -1;
            for (int j = 0; j < sb_q.size(); j++)
                if (k < 0 && sb_q[j].rob == issue_robDest) k = j;
            issue_cnt++;
            chk("sb_match", 32'(k >= 0), 32'd1);
            if (k >= 0) begin
                chk("issue_opA", 32'(issue_opA), 32'(sb_q[k].a));
                chk("issue_opB", 32'(issue_opB), 32'(sb_q[k].b));
                chk("issue_imm", 32'(issue_imm), 32'(sb_q[k].imm));
                chk("issue_ctrl_func", 32'({issue_ctrl, issue_func}), 32'({sb_q[k].ctrl, sb_q[k].func}));
                sb_q.delete(k);
            end
        end
    end

    initial begin
        rst_n = 1'b0; issue_ready = 1'b1;
        clear_pulses();
        rstag1 = 4'd0; rstag2 = 4'd0; rstag3 = 4'd0; rstag4 = 4'd0;
        dataRs1 = 16'd0; dataRt1 = 16'd0; dataRs2 = 16'd0; dataRt2 = 16'd0;
        imm1 = 16'd0; imm2 = 16'd0; ctrl1 = 6'd0; ctrl2 = 6'd0; func1 = 3'd0; func2 = 3'd0;
        robDest1 = 4'd0; robDest2 = 4'd0; spec1 = 1'b0; spec2 = 1'b0;
        cdb1_tag = 4'd0; cdb2_tag = 4'd0; cdb1_data = 16'd0; cdb2_data = 16'd0;
        tick(); tick();
        chk("rst_free_count", 32'(free_count), 32'd8);
        chk("rst_stall", 32'(rs_stall), 32'd0);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_payload", 32'({issue_opA, issue_robDest}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ready operands issue the cycle after dispatch
        drive_slot(1, 4'd0, 4'd0, 16'h0005, 16'h0003, 4'd4, 1'b0, 16'h0005, 16'h0003, 1'b1);
        tick();
        chk("t1_free7", 32'(free_count), 32'd7);
        chk("t1_valid", 32'(issue_valid), 32'd1);
        chk("t1_opA", 32'(issue_opA), 32'h0005);
        chk("t1_rob", 32'(issue_robDest), 32'd4);
        tick();
        chk("t1_free8", 32'(free_count), 32'd8);

        // Tagged operand captured from cdb1, eligible the following cycle
        drive_slot(1, 4'd7, 4'd0, 16'h0000, 16'h0011, 4'd5, 1'b0, 16'hBEEF, 16'h0011, 1'b1);
        tick();
        chk("t2_wait0", 32'(issue_valid), 32'd0);
        tick();
        cdb(1, 4'd7, 16'hBEEF);
        #1;
        chk("t2_capture_cycle", 32'(issue_valid), 32'd0);
        tick();
        chk("t2_valid", 32'(issue_valid), 32'd1);
        chk("t2_opA", 32'(issue_opA), 32'hBEEF);
        tick();

        // Slot 2 alone, operand caught from a same-cycle cdb2 broadcast
        drive_slot(2, 4'd9, 4'd0, 16'h0000, 16'h0022, 4'd6, 1'b0, 16'h1234, 16'h0022, 1'b1);
        cdb(2, 4'd9, 16'h1234);
        tick();
        chk("t3_valid", 32'(issue_valid), 32'd1);
        chk("t3_opA", 32'(issue_opA), 32'h1234);
        tick();

        // Fill seven entries; stall drops the next dispatch
        for (int r = 1; r <= 7; r += 2) begin
            drive_slot(1, 4'(r), 4'd0, 16'd0, 16'(r), 4'(r), 1'b0, 16'hA000 + 16'(r), 16'(r), 1'b1);
            if (r < 7)
                drive_slot(2, 4'(r + 1), 4'd0, 16'd0, 16'(r + 1), 4'(r + 1), 1'b0,
                           16'hA000 + 16'(r + 1), 16'(r + 1), 1'b1);
            tick();
        end
        chk("t4_free1", 32'(free_count), 32'd1);
        chk("t4_stall1", 32'(rs_stall), 32'd1);
        drive_slot(1, 4'd8, 4'd0, 16'd0, 16'd0, 4'd8, 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk("t4_dropped", 32'(free_count), 32'd1);
        cdb(1, 4'd1, 16'hA001);
        tick();
        tick();
        chk("t4_free2", 32'(free_count), 32'd2);
        chk("t4_stall0", 32'(rs_stall), 32'd0);
        for (int r = 2; r <= 6; r += 2) begin
            cdb(1, 4'(r), 16'hA000 + 16'(r));
            cdb(2, 4'(r + 1), 16'hA000 + 16'(r + 1));
            tick();
        end
        repeat (8) tick();
        chk("t4_drain", 32'(free_count), 32'd8);

        // Flush removes speculative entries; non-speculative ones survive
        issue_ready = 1'b0;
        drive_slot(1, 4'd0, 4'd0, 16'h0909, 16'h0009, 4'd9, 1'b0, 16'h0909, 16'h0009, 1'b1);
        drive_slot(2, 4'd10, 4'd0, 16'd0, 16'd1, 4'd10, 1'b1, 16'd0, 16'd1, 1'b1);
        tick();
        drive_slot(1, 4'd11, 4'd0, 16'd0, 16'd1, 4'd11, 1'b1, 16'd0, 16'd1, 1'b1);
        drive_slot(2, 4'd12, 4'd0, 16'd0, 16'd1, 4'd12, 1'b1, 16'd0, 16'd1, 1'b1);
        tick();
        drive_slot(1, 4'd13, 4'd0, 16'd0, 16'h0013, 4'd13, 1'b0, 16'hC013, 16'h0013, 1'b1);
        drive_slot(2, 4'd14, 4'd0, 16'd0, 16'h0014, 4'd14, 1'b0, 16'hC014, 16'h0014, 1'b1);
        tick();
        chk("t5_free2", 32'(free_count), 32'd2);
        chk("t5_hold_rob", 32'(issue_robDest), 32'd9);
        tick();
        chk("t5_hold_rob2", 32'({issue_valid, issue_robDest}), 32'h19);
        flush = 1'b1; issue_ready = 1'b1;
        drive_slot(1, 4'd0, 4'd0, 16'd0, 16'd0, 4'd15, 1'b0, 16'd0, 16'd0, 1'b0);
        cdb(1, 4'd13, 16'hC013);
        #1;
        chk("t5_flush_mask", 32'(issue_valid), 32'd0);
        model_flush();
        tick();
        chk("t5_free5", 32'(free_count), 32'd5);
        cdb(2, 4'd14, 16'hC014);
        tick();
        repeat (5) tick();
        chk("t5_drain", 32'(free_count), 32'd8);

        // spec_resolve clears older spec bits but not the same-cycle dispatch
        drive_slot(1, 4'd1, 4'd0, 16'd0, 16'h0101, 4'd1, 1'b1, 16'hD001, 16'h0101, 1'b1);
        tick();
        spec_resolve = 1'b1;
        foreach (sb_q[j]) sb_q[j].spec = 1'b0;
        drive_slot(1, 4'd2, 4'd0, 16'd0, 16'h0202, 4'd2, 1'b1, 16'd0, 16'h0202, 1'b1);
        tick();
        chk("t5b_free6", 32'(free_count), 32'd6);
        flush = 1'b1;
        model_flush();
        tick();
        chk("t5b_free7", 32'(free_count), 32'd7);
        cdb(1, 4'd1, 16'hD001);
        cdb(2, 4'd2, 16'hD002);
        tick();
        repeat (3) tick();
        chk("t5b_drain", 32'(free_count), 32'd8);

        // Asynchronous reset mid-operation
        issue_ready = 1'b0;
        drive_slot(1, 4'd1, 4'd0, 16'd0, 16'd0, 4'd1, 1'b0, 16'd0, 16'd0, 1'b0);
        drive_slot(2, 4'd2, 4'd0, 16'd0, 16'd0, 4'd2, 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        drive_slot(1, 4'd3, 4'd0, 16'd0, 16'd0, 4'd3, 1'b0, 16'd0, 16'd0, 1'b0);
        drive_slot(2, 4'd4, 4'd0, 16'd0, 16'd0, 4'd4, 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        drive_slot(1, 4'd0, 4'd0, 16'h0505, 16'h0055, 4'd5, 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk("t6_free3", 32'(free_count), 32'd3);
        chk("t6_pre_valid", 32'(issue_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(issue_valid), 32'd0);
        chk("t6_rst_free", 32'(free_count), 32'd8);
        chk("t6_rst_stall", 32'(rs_stall), 32'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        issue_ready = 1'b1;
        snap_cnt = issue_cnt;
        cdb(1, 4'd1, 16'h1111); cdb(2, 4'd2, 16'h2222);
        tick();
        cdb(1, 4'd3, 16'h3333); cdb(2, 4'd4, 16'h4444);
        tick();
        repeat (4) tick();
        chk("t6_no_issue", 32'(issue_cnt), 32'(snap_cnt));
        chk("t6_free8", 32'(free_count), 32'd8);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
